// File: rtl/pp_requant_pack_pkg.sv
// ============================================================================
// Module : pp_pkg
// Brief  : Shared widths, scale-word fields, int8 limits and FSM encoding
//          for the post-processing requantise/pack stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pp_pkg;

  localparam int TOUT      = 4;
  localparam int PSUM_DW   = 32;
  localparam int W_OUT     = 8;
  localparam int AFFINE_DW = 32;
  localparam int AFFINE_AW = 9;
  localparam int W_SIZE    = 9;
  localparam int W_CHANNEL = 9;
  localparam int OFM_DW    = TOUT * W_OUT;
  localparam int OFM_AW    = 16;

  // Scale word layout: unsigned multiplier M and right-shift S.
  localparam int M_LSB = 0;
  localparam int M_W   = 16;
  localparam int S_LSB = 16;
  localparam int S_W   = 5;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  localparam int LEAKY_MUL   = 13;
  localparam int LEAKY_SHIFT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_OUT  = 2'd2
  } pp_state_e;

endpackage

`default_nettype wire

// File: rtl/pp_requant_pack_lane.sv
// ============================================================================
// Module : pp_requant_lane
// Brief  : One lane of bias-add, scale-multiply, rounding shift, activation
//          and int8 saturation. Product registered, tail combinational.
//          Optional macro: PP_LEAKY_RELU_EN (leaky slope instead of ReLU).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_requant_lane
  import pp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_en,
  input  logic                 i_act,
  input  logic [PSUM_DW-1:0]   i_acc,
  input  logic [AFFINE_DW-1:0] i_bias,
  input  logic [AFFINE_DW-1:0] i_scale,
  output logic [W_OUT-1:0]     o_byte
);

  localparam int PROD_W = PSUM_DW + M_W + 2;
  localparam int ACT_W  = PROD_W + 5;

  logic signed [PSUM_DW:0]  w_sum;
  logic signed [M_W:0]      w_m;
  logic signed [PROD_W-1:0] r_prod;
  logic [S_W-1:0]           r_shift;
  logic                     r_act;
  logic signed [PROD_W-1:0] w_rnd;
  logic signed [PROD_W-1:0] w_r;
  logic signed [ACT_W-1:0]  w_a;
  logic                     w_unused_bits;

  assign w_sum = {i_acc[PSUM_DW-1], i_acc} + {i_bias[AFFINE_DW-1], i_bias};
  assign w_m   = {1'b0, i_scale[M_LSB +: M_W]};
  assign w_unused_bits = ^i_scale[AFFINE_DW-1:S_LSB+S_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prod  <= '0;
      r_shift <= '0;
      r_act   <= 1'b0;
    end else if (i_en) begin
      r_prod  <= PROD_W'(w_sum) * PROD_W'(w_m);
      r_shift <= i_scale[S_LSB +: S_W];
      r_act   <= i_act;
    end
  end

  always_comb begin
    w_rnd = '0;
    if (r_shift != '0) w_rnd[r_shift - 1'b1] = 1'b1;
    w_r = (r_prod + w_rnd) >>> r_shift;
    w_a = ACT_W'(w_r);
    if (r_act && w_r[PROD_W-1]) begin
`ifdef PP_LEAKY_RELU_EN
      w_a = (ACT_W'(w_r) * ACT_W'(LEAKY_MUL)) >>> LEAKY_SHIFT;
`else
      w_a = '0;
`endif
    end
    if (w_a > ACT_W'(INT8_MAX))      o_byte = W_OUT'(INT8_MAX);
    else if (w_a < ACT_W'(INT8_MIN)) o_byte = W_OUT'(INT8_MIN);
    else                             o_byte = w_a[W_OUT-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/pp_requant_pack.sv
// ============================================================================
// Module : pp_requant_pack
// Brief  : Requantises a TOUT-lane accumulator vector to int8 one lane at a
//          time and presents the packed OFM word with its address.
//          Optional macro: PP_LEAKY_RELU_EN (selects leaky activation).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_requant_pack
  import pp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [W_SIZE-1:0]         q_width,
  input  logic [W_SIZE-1:0]         q_height,
  input  logic [W_CHANNEL-1:0]      q_channel_out,
  input  logic                      q_act,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [TOUT*PSUM_DW-1:0]   in_data,
  input  logic [W_SIZE-1:0]         in_row,
  input  logic [W_SIZE-1:0]         in_col,
  input  logic [W_CHANNEL-1:0]      in_chn_out,
  output logic                      bias_rd_en,
  output logic [AFFINE_AW-1:0]      bias_rd_addr,
  input  logic [AFFINE_DW-1:0]      bias_rd_data,
  output logic                      scale_rd_en,
  output logic [AFFINE_AW-1:0]      scale_rd_addr,
  input  logic [AFFINE_DW-1:0]      scale_rd_data,
  output logic                      o_pp_data_vld,
  input  logic                      o_pp_rdy,
  output logic [OFM_DW-1:0]         o_pp_data,
  output logic [OFM_AW-1:0]         o_pp_addr,
  output logic                      o_busy,
  output logic                      o_layer_done
);

  localparam int CNT_W  = $clog2(TOUT + 2);
  localparam int LIDX_W = $clog2(TOUT);
  localparam int FULL_W = 2 * W_SIZE + W_CHANNEL + 1;

  pp_state_e                r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [TOUT*PSUM_DW-1:0]  r_data;
  logic [W_SIZE-1:0]        r_row;
  logic [W_SIZE-1:0]        r_col;
  logic [W_CHANNEL-1:0]     r_chn;

  logic [CNT_W-1:0]         w_cnt_m1;
  logic [CNT_W-1:0]         w_cnt_m2;
  logic [LIDX_W-1:0]        w_lane_idx;
  logic [LIDX_W-1:0]        w_commit_idx;
  logic                     w_lane_en;
  logic                     w_commit;
  logic [W_OUT-1:0]         w_lane_byte;
  logic [AFFINE_AW-1:0]     w_base;
  logic [FULL_W-1:0]        w_addr_full;
  logic                     w_last;

  // Read for lane k issues at cnt k, data is back at cnt k+1, byte lands at cnt k+2.
  assign w_cnt_m1     = r_cnt - CNT_W'(1);
  assign w_cnt_m2     = r_cnt - CNT_W'(2);
  assign w_lane_idx   = w_cnt_m1[LIDX_W-1:0];
  assign w_commit_idx = w_cnt_m2[LIDX_W-1:0];
  assign w_lane_en    = (r_state == ST_PROC) && (r_cnt >= CNT_W'(1)) && (r_cnt <= CNT_W'(TOUT));
  assign w_commit     = (r_state == ST_PROC) && (r_cnt >= CNT_W'(2));

  assign w_base      = AFFINE_AW'(in_chn_out * TOUT);
  assign w_addr_full = (FULL_W'(in_row) * FULL_W'(q_width) + FULL_W'(in_col))
                       * FULL_W'(q_channel_out) + FULL_W'(in_chn_out);
  assign w_last      = (r_row == q_height - W_SIZE'(1)) &&
                       (r_col == q_width - W_SIZE'(1)) &&
                       (r_chn == q_channel_out - W_CHANNEL'(1));

  pp_requant_lane u_lane (
    .clk     (clk),
    .rstn    (rstn),
    .i_en    (w_lane_en),
    .i_act   (q_act),
    .i_acc   (r_data[w_lane_idx*PSUM_DW +: PSUM_DW]),
    .i_bias  (bias_rd_data),
    .i_scale (scale_rd_data),
    .o_byte  (w_lane_byte)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_data        <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_chn         <= '0;
      in_rdy        <= 1'b1;
      bias_rd_en    <= 1'b0;
      bias_rd_addr  <= '0;
      scale_rd_en   <= 1'b0;
      scale_rd_addr <= '0;
      o_pp_data_vld <= 1'b0;
      o_pp_data     <= '0;
      o_pp_addr     <= '0;
      o_busy        <= 1'b0;
      o_layer_done  <= 1'b0;
    end else begin
      o_layer_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_vld) begin
            r_state       <= ST_PROC;
            r_cnt         <= '0;
            r_data        <= in_data;
            r_row         <= in_row;
            r_col         <= in_col;
            r_chn         <= in_chn_out;
            in_rdy        <= 1'b0;
            o_busy        <= 1'b1;
            bias_rd_en    <= 1'b1;
            scale_rd_en   <= 1'b1;
            bias_rd_addr  <= w_base;
            scale_rd_addr <= w_base;
            o_pp_addr     <= w_addr_full[OFM_AW-1:0];
          end
        end
        ST_PROC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt < CNT_W'(TOUT - 1)) begin
            bias_rd_addr  <= bias_rd_addr + AFFINE_AW'(1);
            scale_rd_addr <= scale_rd_addr + AFFINE_AW'(1);
          end else begin
            bias_rd_en    <= 1'b0;
            scale_rd_en   <= 1'b0;
            bias_rd_addr  <= '0;
            scale_rd_addr <= '0;
          end
          if (w_commit) o_pp_data[w_commit_idx*W_OUT +: W_OUT] <= w_lane_byte;
          if (r_cnt == CNT_W'(TOUT + 1)) begin
            r_state       <= ST_OUT;
            o_pp_data_vld <= 1'b1;
          end
        end
        ST_OUT: begin
          if (o_pp_rdy) begin
            r_state       <= ST_IDLE;
            o_pp_data_vld <= 1'b0;
            in_rdy        <= 1'b1;
            o_busy        <= 1'b0;
            o_layer_done  <= w_last;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pp_requant_pack.sv
// ============================================================================
// Module : tb_pp_requant_pack
// Brief  : Self-checking bench for pp_requant_pack: directed table, random
//          vectors against an arithmetic model, backpressure, layer_done
//          and mid-operation reset sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pp_requant_pack;

  logic         clk = 1'b0;
  logic         rstn;
  logic [8:0]   q_width, q_height, q_channel_out;
  logic         q_act;
  logic         in_vld;
  logic         in_rdy;
  logic [127:0] in_data;
  logic [8:0]   in_row, in_col, in_chn_out;
  logic         bias_rd_en, scale_rd_en;
  logic [8:0]   bias_rd_addr, scale_rd_addr;
  logic [31:0]  bias_rd_data, scale_rd_data;
  logic         o_pp_data_vld, o_pp_rdy;
  logic [31:0]  o_pp_data;
  logic [15:0]  o_pp_addr;
  logic         o_busy, o_layer_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] bias_mem  [512];
  logic [31:0] scale_mem [512];

  always #5 clk = ~clk;

  pp_requant_pack dut (
    .clk(clk), .rstn(rstn),
    .q_width(q_width), .q_height(q_height), .q_channel_out(q_channel_out), .q_act(q_act),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_row(in_row), .in_col(in_col), .in_chn_out(in_chn_out),
    .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
    .scale_rd_en(scale_rd_en), .scale_rd_addr(scale_rd_addr), .scale_rd_data(scale_rd_data),
    .o_pp_data_vld(o_pp_data_vld), .o_pp_rdy(o_pp_rdy), .o_pp_data(o_pp_data),
    .o_pp_addr(o_pp_addr), .o_busy(o_busy), .o_layer_done(o_layer_done)
  );

  // Affine buffers with one-cycle read latency.
  always @(posedge clk) begin
    if (bias_rd_en)  bias_rd_data  <= bias_mem[bias_rd_addr];
    if (scale_rd_en) scale_rd_data <= scale_mem[scale_rd_addr];
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_lane(input longint acc, input longint bias,
                                          input logic [31:0] sc, input bit act);
    longint m, s, p, r;
    m = longint'(sc[15:0]);
    s = longint'(sc[20:16]);
    p = (acc + bias) * m;
    r = (s > 0) ? ((p + (longint'(1) << (s - 1))) >>> s) : p;
    if (act && r < 0) begin
`ifdef PP_LEAKY_RELU_EN
      r = (r * 13) >>> 7;
`else
      r = 0;
`endif
    end
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // Sends one vector (task entered and left on a negedge) and checks timing,
  // affine read sequence, packed word, address and layer_done.
  task automatic send(input logic [127:0] d, input logic [8:0] row, input logic [8:0] col,
                      input logic [8:0] chn, input logic [31:0] exp_data,
                      input logic [15:0] exp_addr, input bit exp_done, input string nm);
    int lat;
    logic [8:0] base;
    base = 9'(chn * 4);
    in_data = d; in_row = row; in_col = col; in_chn_out = chn; in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    lat = 1;
    while (!o_pp_data_vld && lat < 40) begin
      if (lat <= 6) chk({nm, "_rd_en"}, {bias_rd_en, scale_rd_en}, (lat <= 4) ? 2'b11 : 2'b00);
      if (lat <= 4) chk({nm, "_rd_addr"}, {bias_rd_addr, scale_rd_addr},
                        {base + 9'(lat - 1), base + 9'(lat - 1)});
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 7);
    chk({nm, "_data"}, o_pp_data, exp_data);
    chk({nm, "_addr"}, o_pp_addr, exp_addr);
    chk({nm, "_rdy_busy"}, {in_rdy, o_busy}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_post"}, {o_pp_data_vld, in_rdy, o_busy, o_layer_done}, {3'b010, exp_done});
    @(negedge clk);
    chk({nm, "_done_clr"}, o_layer_done, 1'b0);
  endtask

  task automatic fill_affine(input logic [8:0] chn, input logic [31:0] b, input logic [31:0] s);
    for (int k = 0; k < 4; k++) begin
      bias_mem[9'(chn * 4 + k)]  = b;
      scale_mem[9'(chn * 4 + k)] = s;
    end
  endtask

  typedef struct {
    logic [127:0] d;
    logic [31:0]  bias;
    logic [31:0]  scale;
    bit           act;
    logic [8:0]   qw, qc, row, col, chn;
    logic [31:0]  exp_data;
    logic [15:0]  exp_addr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    logic [127:0] d;
    logic [31:0]  expw;
    logic [8:0]   r9, c9, ch9, base;
    int           qw, qh, qc;
    bit           seen;

    tbl[0] = '{{32'sd50, 32'sd0, -32'sd100, 32'sd100}, 32'd0, 32'h0000_0001, 1'b0,
               9'd4, 9'd1, 9'd0, 9'd0, 9'd0, 32'h3200_9C64, 16'd0};
    tbl[1] = '{{32'sd16, 32'sd0, -32'sd1000, 32'sd1000}, 32'd24, 32'h0004_0003, 1'b0,
               9'd4, 9'd2, 9'd1, 9'd2, 9'd1, 32'h0805_807F, 16'd13};
`ifdef PP_LEAKY_RELU_EN
    tbl[2] = '{{32'sd127, -32'sd1, 32'sd40, -32'sd40}, 32'd0, 32'h0000_0001, 1'b1,
               9'd4, 9'd1, 9'd0, 9'd1, 9'd0, 32'h7FFF_28FB, 16'd1};
    tbl[5] = '{{-32'sd1000000, 32'sd1000000, -32'sd200, 32'sd200}, 32'd0, 32'h0000_0001, 1'b1,
               9'd4, 9'd1, 9'd0, 9'd2, 9'd0, 32'h807F_EB7F, 16'd2};
`else
    tbl[2] = '{{32'sd127, -32'sd1, 32'sd40, -32'sd40}, 32'd0, 32'h0000_0001, 1'b1,
               9'd4, 9'd1, 9'd0, 9'd1, 9'd0, 32'h7F00_2800, 16'd1};
    tbl[5] = '{{-32'sd1000000, 32'sd1000000, -32'sd200, 32'sd200}, 32'd0, 32'h0000_0001, 1'b1,
               9'd4, 9'd1, 9'd0, 9'd2, 9'd0, 32'h007F_007F, 16'd2};
`endif
    tbl[3] = '{{-32'sd5, 32'sd5, -32'sd3, 32'sd3}, 32'd0, 32'h0001_0001, 1'b0,
               9'd4, 9'd1, 9'd0, 9'd3, 9'd0, 32'hFE03_FF02, 16'd3};
    tbl[4] = '{{32'sd0, -32'sd1, 32'sd2, 32'sd1}, 32'd10, 32'hFFF0_FFFF, 1'b0,
               9'd500, 9'd400, 9'd300, 9'd10, 9'd5, 32'h0A09_0C0B, 16'h96A5};

    rstn = 1'b0; in_vld = 1'b0; in_data = '0; in_row = '0; in_col = '0; in_chn_out = '0;
    q_width = 9'd4; q_height = 9'd511; q_channel_out = 9'd1; q_act = 1'b0; o_pp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctrl", {in_rdy, o_pp_data_vld, o_busy, o_layer_done, bias_rd_en, scale_rd_en}, 6'b100000);
    chk("reset_data", {o_pp_data, o_pp_addr, bias_rd_addr, scale_rd_addr}, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      q_width = tbl[i].qw; q_channel_out = tbl[i].qc; q_act = tbl[i].act;
      fill_affine(tbl[i].chn, tbl[i].bias, tbl[i].scale);
      send(tbl[i].d, tbl[i].row, tbl[i].col, tbl[i].chn, tbl[i].exp_data,
           tbl[i].exp_addr, 1'b0, $sformatf("tbl%0d", i));
    end

    // Random vectors against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      qw = int'($urandom_range(1, 20)); qh = int'($urandom_range(1, 20)); qc = int'($urandom_range(1, 8));
      r9 = 9'($urandom_range(0, qh - 1)); c9 = 9'($urandom_range(0, qw - 1)); ch9 = 9'($urandom_range(0, qc - 1));
      q_width = 9'(qw); q_height = 9'(qh); q_channel_out = 9'(qc); q_act = 1'($urandom_range(0, 1));
      base = 9'(ch9 * 4);
      for (int k = 0; k < 4; k++) begin
        logic signed [31:0] a;
        logic [31:0] sc;
        if ($urandom_range(0, 3) == 0) a = $urandom();
        else a = int'($urandom_range(0, 4000)) - 2000;
        sc = $urandom();
        sc[20:16] = 5'($urandom_range(0, 20));
        bias_mem[base + 9'(k)]  = 32'(int'($urandom_range(0, 2000)) - 1000);
        scale_mem[base + 9'(k)] = sc;
        d[k*32 +: 32] = a;
        expw[k*8 +: 8] = ref_lane(longint'(a), longint'($signed(bias_mem[base + 9'(k)])), sc, q_act);
      end
      send(d, r9, c9, ch9, expw, 16'(((int'(r9) * qw + int'(c9)) * qc) + int'(ch9)),
           (int'(r9) == qh - 1) && (int'(c9) == qw - 1) && (int'(ch9) == qc - 1),
           $sformatf("rnd%0d", i));
    end

    // Backpressure: word held stable, second vector waits for handshake
    q_width = 9'd4; q_height = 9'd511; q_channel_out = 9'd1; q_act = 1'b0;
    fill_affine(9'd0, 32'd0, 32'h0000_0001);
    o_pp_rdy = 1'b0;
    in_data = tbl[0].d; in_row = 9'd0; in_col = 9'd0; in_chn_out = 9'd0; in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = {32'sd1, 32'sd2, 32'sd3, 32'sd4}; in_col = 9'd1;
    for (int t = 0; t < 40 && !o_pp_data_vld; t++) @(negedge clk);
    chk("bp_vld", o_pp_data_vld, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (!(o_pp_data_vld && !in_rdy && o_pp_data == 32'h3200_9C64 && o_pp_addr == 16'd0)) seen = 1'b1;
    end
    chk("bp_stable", seen, 1'b0);
    o_pp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", {o_pp_data_vld, in_rdy}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    for (int t = 0; t < 40 && !o_pp_data_vld; t++) @(negedge clk);
    chk("bp_second", {o_pp_data_vld, o_pp_data, o_pp_addr}, {1'b1, 32'h0102_0304, 16'd1});
    @(posedge clk);
    @(negedge clk);

    // 2x2 layer, one channel tile: layer_done only after the 4th word
    q_width = 9'd2; q_height = 9'd2; q_channel_out = 9'd1;
    for (int i = 0; i < 4; i++)
      send({32'sd7, 32'sd6, 32'sd5, 32'(i)}, 9'(i / 2), 9'(i % 2), 9'd0,
           {8'd7, 8'd6, 8'd5, 8'(i)}, 16'(i), i == 3, $sformatf("layer%0d", i));

    // Reset while processing drops the vector
    in_data = tbl[0].d; in_row = 9'd0; in_col = 9'd0; in_chn_out = 9'd0; in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_ctrl", {in_rdy, o_pp_data_vld, o_busy, o_layer_done, bias_rd_en, scale_rd_en}, 6'b100000);
    chk("midrst_data", {o_pp_data, o_pp_addr, bias_rd_addr}, '0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (o_pp_data_vld || o_busy) seen = 1'b1;
    end
    chk("midrst_no_emit", seen, 1'b0);
    q_width = 9'd4; q_height = 9'd511;
    send(tbl[0].d, 9'd0, 9'd0, 9'd0, 32'h3200_9C64, 16'd0, 1'b0, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
